// File: rtl/prom_boot_copier_if.sv
// PROM read port and RAM write port used by the boot copier.
// The master side is the copier; the slave side is the memory/arbiter side.
interface prom_boot_copier_if #(
   parameter int DST_AW = 18
);
   logic [8:0]        prom_addr;
   logic [31:0]       prom_data;
   logic              ram_req;
   logic [DST_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_ack;

   modport master (
      output prom_addr,
      input  prom_data,
      output ram_req,
      output ram_addr,
      output ram_wdata,
      input  ram_ack
   );

   modport slave (
      input  prom_addr,
      output prom_data,
      input  ram_req,
      input  ram_addr,
      input  ram_wdata,
      output ram_ack
   );
endinterface

// File: rtl/prom_boot_copier.sv
// Boot sequencer: copies NWORDS words from the boot PROM into main RAM,
// sums them into a 32-bit checksum and holds the CPU off until the first copy ends.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start or the one-shot autostart after reset
// S_READ  | prom_addr presented, PROM samples it at the end of this cycle
// S_WAIT  | prom_data valid, captured into ram_wdata, ram_req raised
// S_WRITE | ram_req/ram_addr/ram_wdata held until ram_ack
// S_DONE  | copy finished, done sticky, start re-runs the copy
module prom_boot_copier #(
   parameter int NWORDS    = 512,
   parameter int DST_AW    = 18,
   parameter int DST_BASE  = 0,
   parameter bit AUTOSTART = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   prom_boot_copier_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic [31:0]         csum,
   output logic                cpu_hold
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [8:0]        LAST_IDX = 9'(NWORDS - 1);
   localparam logic [DST_AW-1:0] BASE     = DST_AW'(DST_BASE);
   localparam logic [DST_AW-1:0] ONE_A    = DST_AW'(1);

   logic [2:0] state;
   logic [8:0] cnt;
   logic       auto_pend;
   logic       launch;

   // start and the autostart flag collapse into a single launch; start while busy is dropped
   assign launch = ((state == S_IDLE) && (start || auto_pend)) ||
                   ((state == S_DONE) && start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= 9'd0;
         auto_pend     <= AUTOSTART;
         bus.prom_addr <= 9'd0;
         bus.ram_req   <= 1'b0;
         bus.ram_addr  <= BASE;
         bus.ram_wdata <= 32'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         csum          <= 32'd0;
         cpu_hold      <= 1'b1;
      end else begin
         auto_pend <= 1'b0;
         if (launch) begin
            state         <= S_READ;
            cnt           <= 9'd0;
            bus.prom_addr <= 9'd0;
            bus.ram_addr  <= BASE;
            csum          <= 32'd0;
            done          <= 1'b0;
            busy          <= 1'b1;
         end else begin
            case (state)
               S_READ: begin
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  bus.ram_wdata <= bus.prom_data;
                  bus.ram_req   <= 1'b1;
                  state         <= S_WRITE;
               end
               S_WRITE: begin
                  if (bus.ram_ack) begin
                     bus.ram_req <= 1'b0;
                     csum        <= csum + bus.ram_wdata;
                     if (cnt == LAST_IDX) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                     end else begin
                        cnt           <= cnt + 9'd1;
                        bus.prom_addr <= bus.prom_addr + 9'd1;
                        bus.ram_addr  <= bus.ram_addr + ONE_A;
                        state         <= S_READ;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: doc/prom_boot_copier.md
Name: prom_boot_copier

Overview:
Boot sequencer that runs after reset. It reads a fixed number of words from the 512x32 boot PROM, copies them into main RAM through a request/acknowledge write port, and accumulates a 32-bit additive checksum. The CPU is held off until the copy completes. The block sits between the PROM, the RAM write arbiter and the CPU reset/run logic.

Parameters:
NWORDS, 512, number of words to copy (1..512); copies PROM addresses 0..NWORDS-1.
DST_AW, 18, RAM word-address width.
DST_BASE, 0, RAM word address of the first destination word; must satisfy DST_BASE+NWORDS <= 2**DST_AW.
AUTOSTART, 1, 1 = start the copy automatically on the first cycle after reset release.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; starts a copy when idle or done
prom_addr  out  9  PROM word address (registered)
prom_data  in  32  PROM read data, valid one cycle after prom_addr is presented (synchronous read)
ram_req  out  1  RAM write request
ram_addr  out  DST_AW  RAM word address (registered)
ram_wdata  out  32  RAM write data (registered)
ram_ack  in  1  RAM write accepted when high at a clk edge with ram_req high
busy  out  1  copy in progress
done  out  1  sticky: last copy completed
csum  out  32  running/final checksum
cpu_hold  out  1  high until the first copy completes

Behaviour:
- Reset values (async, rst_n low): state IDLE, prom_addr=0, ram_req=0, ram_addr=DST_BASE, ram_wdata=0, busy=0, done=0, csum=0, cpu_hold=1, word counter=0.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: go to READ when start=1, or on the first cycle after reset release if AUTOSTART=1 (one-shot flag). On entry to READ: counter=0, prom_addr=0, ram_addr=DST_BASE, csum=0, done=0, busy=1.
- READ: prom_addr is stable and the PROM samples it at the end of this cycle. Next state is WAIT.
- WAIT: prom_data is valid. At the clock edge, ram_wdata<=prom_data and ram_req<=1. Next state is WRITE.
- WRITE: ram_req, ram_addr and ram_wdata are held stable until ram_ack=1 is sampled. On ack:
  - ram_req<=0
  - csum<=csum+ram_wdata (mod 2^32)
  - If counter==NWORDS-1: go to DONE.
  - Otherwise: counter+1, prom_addr+1, ram_addr+1, go to READ.
- Throughput is 3 cycles per word when ack is immediate, giving a minimum of 3*NWORDS cycles from READ entry to DONE entry.
- DONE: busy=0, done=1, cpu_hold=0. cpu_hold never reasserts until the next reset. start=1 re-enters READ (re-copy) with done cleared and csum reset.
- start while busy is ignored with no effect.
- start and the AUTOSTART trigger in the same cycle produce a single copy.
- ram_ack while ram_req=0 is ignored.
- ram_req is never asserted outside WRITE and never drops before ack.
- NWORDS=1: single READ/WAIT/WRITE pass, then DONE.
- Last word: prom_addr does not increment past NWORDS-1.
- Counter and address arithmetic are unsigned with no wrap within legal parameters.
- Reset mid-copy: immediate async return to reset values. ram_req drops asynchronously and cpu_hold returns high. With AUTOSTART=1 the copy restarts from word 0 after release.

Test Plan:
- AUTOSTART=1, NWORDS=4, PROM={1,2,3,4}, ram_ack tied high → writes (DST_BASE+0..3, 1..4). DONE entered 12 cycles after READ entry. csum=10, cpu_hold falls together with done rising.
- ram_ack delayed 0/3/1/5 cycles per word → ram_req, ram_addr and ram_wdata stable throughout each wait. One write per ack. Same csum=10.
- PROM words 0xFFFFFFFF and 0x00000002, NWORDS=2 → csum=0x00000001 (wrap mod 2^32).
- start pulsed during WRITE of word 1 → ignored, exactly NWORDS writes. start pulsed in DONE → second identical copy, done low while busy, cpu_hold stays 0.
- rst_n asserted while ram_req=1 at word 2 → ram_req=0 and cpu_hold=1 immediately. After release, the copy restarts at prom_addr=0 and ram_addr=DST_BASE.
- AUTOSTART=0, NWORDS=512 → idle until start. Then 512 writes, final prom_addr=511, ram_addr=DST_BASE+511, and csum equals the software sum of all 512 PROM words.
